// File: rtl/array_sweep_pkg.sv
// Shared types and default geometry for the array sweep scheduler.
package array_sweep_pkg;

    localparam int DEPTH_DEF = 128;
    localparam int WIDTH_DEF = 32;
    localparam int AW_DEF    = 7;

    // Engine states: idle, bulk clear, and the two halves of one read-modify-write.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLR    = 2'd1,
        SWP_RD = 2'd2,
        SWP_WR = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/array_sweep_arb.sv
// Host-versus-sweep arbitration for the shared memory port.
// The host may only take a slot that would otherwise be a sweep read, so a
// sweep entry's read and write are never split. After the host wins a slot
// during a sweep, it must wait until at least one sweep entry completes.
module array_sweep_arb
    import array_sweep_pkg::*;
(
    input  logic         clock,
    input  logic         resetn,
    input  sweep_state_e state,
    input  logic         hreq,
    output logic         hgnt
);

    logic fair_q, fair_d;

    // Grant decision: always in IDLE, in a sweep read slot only if the host did not just win one.
    always_comb begin
        hgnt = resetn & hreq & ((state == IDLE) | ((state == SWP_RD) & ~fair_q));
    end

    // Fairness flag: set by a grant inside the sweep, cleared once an entry write lands or the engine is idle.
    always_comb begin
        fair_d = fair_q;
        if (state == IDLE || state == SWP_WR) begin
            fair_d = 1'b0;
        end else if (hgnt) begin
            fair_d = 1'b1;
        end
    end

    // Fairness flag register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fair_q <= 1'b0;
        end else begin
            fair_q <= fair_d;
        end
    end

endmodule

// File: rtl/array_sweep_scheduler.sv
// Sole master of a single-port synchronous memory. Runs either a bulk clear
// (zero every entry) or an increment sweep (entry += 1, one read-modify-write
// per entry) and lets a host port borrow sweep read slots.
module array_sweep_scheduler
    import array_sweep_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    input  logic             hreq,
    input  logic             hwe,
    input  logic [AW-1:0]    haddr,
    input  logic [WIDTH-1:0] hwdata,
    output logic             hgnt,
    output logic             hvalid,
    output logic [WIDTH-1:0] hrdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    sweep_state_e   state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           done_q, done_d;
    logic           hvalid_q, hvalid_d;
    logic           host_gnt;

    array_sweep_arb u_arb (
        .clock  (clock),
        .resetn (resetn),
        .state  (state_q),
        .hreq   (hreq),
        .hgnt   (host_gnt)
    );

    // State and entry address register; reset abandons any sweep or clear in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next state: clear beats start in IDLE; both are ignored outside IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLR;
                    addr_d  = '0;
                end else if (start) begin
                    state_d = SWP_RD;
                    addr_d  = '0;
                end
            end
            CLR: begin
                if (addr_q == LAST) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            SWP_RD: begin
                // A host grant takes this slot; the sweep read is retried next cycle.
                if (!host_gnt) begin
                    state_d = SWP_WR;
                end
            end
            SWP_WR: begin
                if (addr_q == LAST) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    state_d = SWP_RD;
                    addr_d  = addr_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    // Host read data is valid the cycle after its grant.
    always_comb begin
        hvalid_d = host_gnt & ~hwe;
    end

    // Completion pulse and host read-valid registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            done_q   <= 1'b0;
            hvalid_q <= 1'b0;
        end else begin
            done_q   <= done_d;
            hvalid_q <= hvalid_d;
        end
    end

    // Memory port drive: host access when granted, otherwise the engine's own access.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE, SWP_RD: begin
                if (host_gnt) begin
                    mem_en    = 1'b1;
                    mem_we    = hwe;
                    mem_addr  = haddr;
                    mem_wdata = hwe ? hwdata : '0;
                end else if (state_q == SWP_RD) begin
                    mem_en   = 1'b1;
                    mem_addr = addr_q;
                end
            end
            CLR: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = addr_q;
            end
            SWP_WR: begin
                // Increment wraps at WIDTH bits.
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = mem_rdata + WIDTH'(1);
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign hgnt   = host_gnt;
    assign hvalid = hvalid_q;
    assign hrdata = hvalid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_array_sweep_scheduler.sv
// Directed bench for array_sweep_scheduler with a behavioural single-port RAM.
// Host reads push the expected word into a queue; a forked monitor pops on hvalid.
module tb_array_sweep_scheduler;

    localparam int DEPTH = 128;
    localparam int WIDTH = 32;
    localparam int AW    = 7;
    localparam int GBUD  = 1000;
    localparam int DBUD  = 2000;

    typedef struct packed {
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
    } exp_t;

    logic             clock, resetn, start, clear, busy, done;
    logic             hreq, hwe, hgnt, hvalid;
    logic [AW-1:0]    haddr, mem_addr;
    logic [WIDTH-1:0] hwdata, hrdata, mem_wdata, mem_rdata;
    logic             mem_en, mem_we;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] exp_arr [DEPTH];
    exp_t             q [$];
    int               n_cmp, n_err, rst_wr;

    array_sweep_scheduler #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clock(clock), .resetn(resetn), .start(start), .clear(clear),
        .busy(busy), .done(done), .hreq(hreq), .hwe(hwe), .haddr(haddr),
        .hwdata(hwdata), .hgnt(hgnt), .hvalid(hvalid), .hrdata(hrdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single-port synchronous RAM; contents survive DUT reset.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
        if (!resetn && mem_en && mem_we) rst_wr <= rst_wr + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Host access; caller is at a negedge, returns at a negedge with hreq dropped.
    task automatic host_acc(input bit we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                            output int waited);
        hreq = 1'b1; hwe = we; haddr = a; hwdata = d; waited = 0;
        #1;
        while (!hgnt && waited < GBUD) begin
            @(negedge clock); #1;
            waited++;
        end
        if (!hgnt) begin
            n_cmp++; n_err++;
            $display("FAIL grant_timeout: addr %0d waited %0d cycles", a, waited);
        end else if (!we) begin
            q.push_back('{a: a, d: d});
        end
        @(negedge clock);
        hreq = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [WIDTH-1:0] e);
        int w;
        host_acc(1'b0, a, e, w);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        int w;
        host_acc(1'b1, a, d, w);
    endtask

    task automatic rd_all();
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), exp_arr[i]);
    endtask

    // Waits for done from a negedge; cyc counts negedges passed.
    task automatic wait_done(inout int cyc);
        while (!done && cyc < DBUD) begin
            @(negedge clock);
            cyc++;
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: no done after %0d cycles", cyc);
        end
    endtask

    // Issues a start (and optionally clear) pulse; returns at the first negedge after the sampling edge.
    task automatic pulse(input bit st, input bit cl);
        start = st; clear = cl;
        @(negedge clock);
        start = 1'b0; clear = 1'b0;
    endtask

    // Read-data scoreboard plus grant atomicity / fairness observer.
    task automatic monitor();
        exp_t e;
        bit prev_rd, g_seen, wr_since, srd, swr;
        prev_rd = 0; g_seen = 0; wr_since = 0;
        forever begin
            @(negedge clock); #2;
            if (hvalid) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL hvalid_unexpected: hrdata %0h with no read outstanding", hrdata);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("hrdata[%0d]", e.a), hrdata, e.d);
                end
            end
            srd = busy && mem_en && !mem_we && !hgnt;
            swr = busy && mem_en && mem_we && !hgnt;
            if (busy && hgnt) begin
                chk("grant_inside_rmw", prev_rd, 0);
                if (g_seen) chk("grant_fairness", wr_since, 1);
                g_seen = 1; wr_since = 0;
            end
            if (swr) wr_since = 1;
            if (!busy) g_seen = 0;
            prev_rd = srd;
        end
    endtask

    initial begin
        int cyc, grants, zwr, oth, w;
        n_cmp = 0; n_err = 0; rst_wr = 0;
        resetn = 1'b0; start = 1'b0; clear = 1'b0;
        hreq = 1'b1; hwe = 1'b1; haddr = '0; hwdata = 32'hDEAD_BEEF;
        fork monitor(); join_none

        // Reset state, with a host request and write data pending.
        #3;
        chk("reset_ctl", {busy, done, hgnt, hvalid, mem_en, mem_we}, 6'b0);
        chk("reset_hrdata", hrdata, 0);
        chk("reset_wdata", mem_wdata, 0);
        @(negedge clock); @(negedge clock);
        hreq = 1'b0; resetn = 1'b1;
        @(negedge clock);

        // Clear, then uncontended sweep: every entry ends at 1.
        pulse(1'b0, 1'b1);
        cyc = 0; wait_done(cyc);
        chk("clear_cycles", cyc, 128);
        @(negedge clock);
        pulse(1'b1, 1'b0);
        chk("busy_in_sweep", busy, 1);
        cyc = 0; wait_done(cyc);
        chk("sweep_cycles", cyc, 256);
        chk("busy_at_done", busy, 0);
        @(negedge clock);
        chk("done_one_cycle", done, 0);
        for (int i = 0; i < DEPTH; i++) exp_arr[i] = 32'd1;
        rd_all();

        // start and clear together: clear only, 128 zero writes.
        pulse(1'b1, 1'b1);
        cyc = 0; zwr = 0; oth = 0;
        while (!done && cyc < DBUD) begin
            if (mem_en && mem_we && mem_wdata == 0) zwr++;
            else oth++;
            @(negedge clock); cyc++;
        end
        chk("clr_only_cycles", cyc, 128);
        chk("clr_zero_writes", zwr, 128);
        chk("clr_other_cycles", oth, 0);
        @(negedge clock);
        chk("clr_start_dropped", busy, 0);
        for (int i = 0; i < DEPTH; i++) exp_arr[i] = 32'd0;
        rd(0, 0); rd(64, 0); rd(127, 0);

        // Wrap: entry 5 = all ones sweeps to 0; IDLE grant is immediate.
        host_acc(1'b1, 5, 32'hFFFF_FFFF, w);
        chk("idle_grant_wait", w, 0);
        pulse(1'b1, 1'b0);
        cyc = 0; wait_done(cyc);
        @(negedge clock);
        rd(5, 32'h0); rd(6, 32'h1);
        for (int i = 0; i < DEPTH; i++) exp_arr[i] = 32'd1;
        exp_arr[5] = 32'd0;

        // Continuous host reads of entry 127 during a sweep: grant every third cycle.
        pulse(1'b1, 1'b0);
        hreq = 1'b1; hwe = 1'b0; haddr = 127;
        cyc = 0; grants = 0;
        while (cyc < DBUD) begin
            #1;
            if (done) break;
            if (hgnt) begin
                q.push_back('{a: 7'd127, d: 32'd1});
                grants++;
            end
            @(negedge clock); cyc++;
        end
        hreq = 1'b0;
        chk("hold_done_cycles", cyc, 384);
        chk("hold_grants", grants, 128);
        @(negedge clock);
        for (int i = 0; i < DEPTH; i++) exp_arr[i] = 32'd2;
        exp_arr[5] = 32'd1;

        // Host writes while sweep is at entry 50: ahead gets incremented, behind does not.
        pulse(1'b1, 1'b0);
        cyc = 0;
        while (cyc < 100) begin @(negedge clock); cyc++; end
        wr(100, 32'h10);
        wr(10, 32'h10);
        cyc = 0; wait_done(cyc);
        @(negedge clock);
        for (int i = 0; i < DEPTH; i++) exp_arr[i] = 32'd3;
        exp_arr[5] = 32'd2; exp_arr[100] = 32'h11; exp_arr[10] = 32'h10;
        rd(100, 32'h11); rd(10, 32'h10); rd(5, 32'd2); rd(99, 32'd3); rd(101, 32'd3);

        // Reset during entry 64's read slot.
        pulse(1'b1, 1'b0);
        cyc = 0;
        while (cyc < 128) begin @(negedge clock); cyc++; end
        resetn = 1'b0; hreq = 1'b1; hwe = 1'b1; haddr = 3; hwdata = 32'h55;
        #1;
        chk("midrst_ctl", {busy, done, hgnt, hvalid, mem_en, mem_we}, 6'b0);
        chk("midrst_hrdata", hrdata, 0);
        chk("midrst_wdata", mem_wdata, 0);
        @(negedge clock); @(negedge clock);
        hreq = 1'b0; resetn = 1'b1;
        @(negedge clock);
        chk("midrst_idle", busy, 0);
        for (int i = 0; i < 64; i++) exp_arr[i] = 32'd4;
        exp_arr[5] = 32'd3; exp_arr[10] = 32'h11;
        rd_all();
        chk("writes_during_reset", rst_wr, 0);

        @(negedge clock); @(negedge clock);
        chk("reads_outstanding", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/array_sweep_scheduler.md
ARRAY_SWEEP_SCHEDULER -- requirements
Module: array_sweep_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 128, number of array entries.
- WIDTH, 32, entry width in bits.
- AW, 7, address width, equal to clog2(DEPTH).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, rising-edge clock.
- resetn, in, 1, reset: asynchronous, active-low.
- start, in, 1, pulse; request one increment sweep.
- clear, in, 1, pulse; request a bulk zero of the array.
- busy, out, 1, high while a sweep or clear is in progress.
- done, out, 1, one-cycle pulse at sweep or clear completion.
- hreq, in, 1, host access request; held until granted.
- hwe, in, 1, host write (1) or read (0); valid with hreq.
- haddr, in, AW, host address.
- hwdata, in, WIDTH, host write data.
- hgnt, out, 1, one-cycle grant; the access executes this cycle.
- hvalid, out, 1, host read data valid.
- hrdata, out, WIDTH, host read data.
- mem_en, out, 1, memory port enable.
- mem_we, out, 1, memory write enable.
- mem_addr, out, AW, memory address.
- mem_wdata, out, WIDTH, memory write data.
- mem_rdata, in, WIDTH, memory read data, valid one cycle after a read.

Function
REQ-003 The block SHALL be the sole master of one external single-port synchronous memory and share it between the sweep engine and the host port.
REQ-004 States SHALL be IDLE, CLR, SWP_RD, SWP_WR.
REQ-005 In IDLE, clear SHALL enter CLR at address 0; if start and clear are asserted in the same cycle, clear SHALL win and start SHALL be dropped.
REQ-006 In IDLE, start SHALL enter SWP_RD at address 0.
REQ-007 start and clear SHALL be ignored while busy and SHALL not be queued.
REQ-008 CLR SHALL write 0 to one entry per cycle, for DEPTH cycles, with no host grant during CLR.
REQ-009 SWP_RD SHALL issue a read of entry n; the next cycle, SWP_WR SHALL write mem_rdata+1 to entry n, truncated to WIDTH bits (0xFFFFFFFF wraps to 0).
REQ-010 SWP_WR SHALL advance to SWP_RD for entry n+1, or to IDLE after entry DEPTH-1.
REQ-011 An uncontended sweep SHALL take exactly 2*DEPTH cycles from the start-sampled edge.
REQ-012 done SHALL pulse for one cycle in the cycle after the last sweep or clear write; busy SHALL fall in that same cycle.
REQ-013 A host grant SHALL occur only in IDLE, or in place of an SWP_RD cycle; it SHALL never occur between the SWP_RD and SWP_WR of one entry, so each read-modify-write is atomic.
REQ-014 Fairness: after a host grant during a sweep, at least one sweep entry SHALL complete before the next host grant.
REQ-015 In IDLE, a pending hreq SHALL be granted in the cycle it is sampled.
REQ-016 A host read SHALL drive hvalid high with hrdata exactly one cycle after hgnt.
REQ-017 A host write SHALL update the memory in the hgnt cycle.
REQ-018 A host write to an entry the sweep has already passed SHALL not be re-incremented; a host write to a later entry SHALL be incremented when the sweep reaches it.
REQ-019 mem_en SHALL be 0 in any cycle with no access.

Reset
REQ-020 Asserting resetn low SHALL immediately force IDLE, set the address counter and fairness flag to 0, and drive busy, done, hgnt, hvalid, mem_en and mem_we to 0; hrdata and mem_wdata SHALL be 0.
REQ-021 Reset mid-sweep SHALL abandon the sweep with no further memory writes; array contents are not restored.

Structure
REQ-022 Package array_sweep_pkg SHALL hold the state enum and the DEPTH, WIDTH and AW defaults.
REQ-023 A sub-module array_sweep_arb SHALL implement the host-versus-sweep grant decision and the fairness flag.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- clear, then start, no host traffic -> done 256 cycles after start; every entry reads 1.
- Preload entry 5 = 0xFFFFFFFF, then sweep -> entry 5 = 0, entry 6 = 1.
- hreq held continuously during a sweep -> sweep and host grants alternate, never within one entry's RD/WR pair, and each grant is followed by at least one sweep entry; done arrives later than 256 cycles after start.
- Host writes 0x10 to entry 100 while the sweep is at entry 50 -> final value 0x11; host writes 0x10 to entry 10 at the same point -> final value 0x10.
- start and clear in the same cycle -> CLR only; 128 zero writes, then done.
- resetn low at sweep entry 64 -> outputs 0 at once; entries 0-63 hold +1, entries 64-127 are unchanged.
